// File: rtl/mem_access_unit.sv
// Load/store sequencer: byte and little-endian halfword accesses to a byte-wide data memory,
// range-checked against the three-bank data space at acceptance.
module mem_access_unit #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned RAMSIZE = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_half,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ACC0 = 3'd1;
    localparam logic [2:0] ACC1 = 3'd2;
    localparam logic [2:0] FIN  = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    localparam logic [WIDTH:0] LIMIT = (WIDTH + 1)'(3 * RAMSIZE);

    logic [2:0]       state_q, state_d;
    logic             write_q, half_q;
    logic [WIDTH-1:0] addr_q;
    logic [15:0]      wdata_q;
    logic [7:0]       lo_q;

    logic [WIDTH:0]   addr_ext, addr_ext_p1;
    logic [WIDTH-1:0] addr_p1;
    logic             range_err;
    logic             accept;
    logic             unused_rd;

    // One extra bit so the top address plus one cannot wrap back into range.
    assign addr_ext    = {1'b0, req_addr};
    assign addr_ext_p1 = addr_ext + (WIDTH + 1)'(1);
    assign range_err   = (addr_ext >= LIMIT) || (req_half && (addr_ext_p1 >= LIMIT));

    assign addr_p1   = addr_q + WIDTH'(1);
    assign accept    = (state_q == IDLE) && req_valid;
    assign unused_rd = ^mem_rd[WIDTH-1:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            half_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= req_write;
                half_q  <= req_half;
                addr_q  <= req_addr;
                wdata_q <= req_wdata[15:0];
                lo_q    <= '0;
            end else if (state_q == ACC1 && !write_q) begin
                lo_q <= mem_rd[7:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = range_err ? ERR : ACC0;
                end
            end
            ACC0:     state_d = half_q ? ACC1 : FIN;
            ACC1:     state_d = FIN;
            FIN, ERR: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_we     = 1'b0;
        mem_a      = '0;
        mem_wd     = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state_q)
            ACC0: begin
                mem_a = addr_q;
                if (write_q) begin
                    mem_we      = 1'b1;
                    mem_wd[7:0] = wdata_q[7:0];
                end
            end
            ACC1: begin
                mem_a = addr_p1;
                if (write_q) begin
                    mem_we      = 1'b1;
                    mem_wd[7:0] = wdata_q[15:8];
                end
            end
            FIN: begin
                mem_a      = half_q ? addr_p1 : addr_q;
                resp_valid = 1'b1;
                // The final byte arrives on mem_rd during FIN itself, so it is merged here.
                if (!write_q) begin
                    if (half_q) begin
                        resp_rdata[15:8] = mem_rd[7:0];
                        resp_rdata[7:0]  = lo_q;
                    end else begin
                        resp_rdata[7:0] = mem_rd[7:0];
                    end
                end
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: per-cycle trace model, byte memory, directed and
// randomized accesses.
module tb_mem_access_unit;

    localparam logic [15:0] MEMSZ = 16'd12288;

    typedef struct {
        logic        rdy;
        logic        we;
        logic [15:0] a;
        logic [15:0] wd;
        logic        rv;
        logic        er;
        logic [15:0] rd;
    } cyc_t;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write, req_half;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [15:0] resp_rdata;
    logic        mem_we;
    logic [15:0] mem_a, mem_wd, mem_rd;

    logic [7:0]  mem     [0:12287];
    logic [7:0]  ref_mem [0:12287];
    cyc_t        want_q[$];
    cyc_t        want;
    logic [31:0] wlog[$];
    int          total, bad, cyc, acc_cyc, last_lat, n;
    logic [15:0] last_rdata, a;
    logic        last_err;

    mem_access_unit #(.WIDTH(16), .RAMSIZE(4096)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_half   (req_half),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 32'h1000) return 8'h5A;
        return 8'(i * 73 + (i >> 4) + 11);
    endfunction

    function automatic cyc_t mk(input logic rdy, we, input logic [15:0] ma, wd,
                                input logic rv, er, input logic [15:0] rd);
        cyc_t c;
        c.rdy = rdy; c.we = we; c.a = ma; c.wd = wd; c.rv = rv; c.er = er; c.rd = rd;
        return c;
    endfunction

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, req, $time);
        end
    endtask

    // Byte-wide data memory: synchronous read, junk in the unused upper bits.
    initial begin
        cyc = 0;
        for (int i = 0; i < 12288; i++) mem[i] = init_byte(i);
        mem_rd = '0;
        forever begin
            @(posedge clk);
            mem_rd <= {8'($urandom), (mem_a < MEMSZ) ? mem[mem_a] : 8'h00};
            if (mem_we && mem_a < MEMSZ) mem[mem_a] = mem_wd[7:0];
        end
    end

    // Reference model: expected output trace of one access, one entry per busy cycle.
    task automatic model_access(input logic w, h, input logic [15:0] ad, wd, output int cnt);
        logic [16:0] a17;
        logic [15:0] a1, rd;
        a17 = {1'b0, ad};
        a1  = ad + 16'd1;
        if (a17 >= 17'd12288 || (h && (a17 + 17'd1) >= 17'd12288)) begin
            want_q.push_back(mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0));
            cnt = 1;
        end else begin
            rd = w ? 16'h0 : (h ? {ref_mem[a1], ref_mem[ad]} : {8'h00, ref_mem[ad]});
            want_q.push_back(mk(1'b0, w, ad, w ? {8'h00, wd[7:0]} : 16'h0, 1'b0, 1'b0, 16'h0));
            if (h) want_q.push_back(mk(1'b0, w, a1, w ? {8'h00, wd[15:8]} : 16'h0,
                                       1'b0, 1'b0, 16'h0));
            want_q.push_back(mk(1'b0, 1'b0, h ? a1 : ad, 16'h0, 1'b1, 1'b0, rd));
            if (w) begin
                ref_mem[ad] = wd[7:0];
                if (h) ref_mem[a1] = wd[15:8];
            end
            cnt = h ? 3 : 2;
        end
    endtask

    // Single compare process: every cycle out of reset, against the model trace or idle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (want_q.size() > 0) want = want_q.pop_front();
            else want = mk(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
            chk1 ("req_ready",  req_ready,  want.rdy);
            chk1 ("mem_we",     mem_we,     want.we);
            chk16("mem_a",      mem_a,      want.a);
            chk16("mem_wd",     mem_wd,     want.wd);
            chk1 ("resp_valid", resp_valid, want.rv);
            chk1 ("resp_err",   resp_err,   want.er);
            chk16("resp_rdata", resp_rdata, want.rd);
            if (mem_we) wlog.push_back({mem_a, mem_wd});
            if (resp_valid) begin
                last_rdata = resp_rdata;
                last_err   = resp_err;
                last_lat   = cyc - acc_cyc + 1;
            end
        end
    end

    task automatic scramble();
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        req_write = 1'($urandom);
        req_half  = 1'($urandom);
    endtask

    // Entered and left at posedge+1 with the DUT idle.
    task automatic issue(input logic w, h, input logic [15:0] ad, wd, input logic hold);
        int cnt;
        req_write = w; req_half = h; req_addr = ad; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        model_access(w, h, ad, wd, cnt);
        if (!hold) req_valid = 1'b0;
        for (int k = 0; k < cnt; k++) begin
            scramble();
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; last_lat = 0; last_err = 1'b0; last_rdata = '0; acc_cyc = 0;
        for (int i = 0; i < 12288; i++) ref_mem[i] = init_byte(i);
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_half = 1'b0;
        req_addr = 16'h1234; req_wdata = 16'hFFFF;
        #2;
        chk1 ("rst_ready", req_ready, 1'b1);
        chk1 ("rst_we", mem_we, 1'b0);
        chk16("rst_a", mem_a, 16'h0);
        chk16("rst_wd", mem_wd, 16'h0);
        chk1 ("rst_rv", resp_valid, 1'b0);
        chk1 ("rst_err", resp_err, 1'b0);
        chk16("rst_rdata", resp_rdata, 16'h0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end

        // Halfword store then load, little-endian.
        wlog.delete();
        issue(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        chk16("st_half_nwr", 16'(wlog.size()), 16'd2);
        if (wlog.size() == 2) begin
            chk16("st_half_w0a", wlog[0][31:16], 16'h0010);
            chk16("st_half_w0d", wlog[0][15:0],  16'h00EF);
            chk16("st_half_w1a", wlog[1][31:16], 16'h0011);
            chk16("st_half_w1d", wlog[1][15:0],  16'h00BE);
        end
        issue(1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0);
        chk16("ld_half_data", last_rdata, 16'hBEEF);
        chk1 ("ld_half_err", last_err, 1'b0);
        chk16("ld_half_lat", 16'(last_lat), 16'd3);

        // Byte load from bank 1.
        issue(1'b0, 1'b0, 16'h1000, 16'h0000, 1'b0);
        chk16("ld_byte_data", last_rdata, 16'h005A);
        chk16("ld_byte_lat", 16'(last_lat), 16'd2);

        // Halfword straddling the bank boundary.
        wlog.delete();
        issue(1'b1, 1'b1, 16'h0FFF, 16'h1234, 1'b0);
        chk16("cross_nwr", 16'(wlog.size()), 16'd2);
        if (wlog.size() == 2) begin
            chk16("cross_w0", wlog[0][31:16] ^ wlog[0][15:0], 16'h0FFF ^ 16'h0034);
            chk16("cross_w1", wlog[1][31:16] ^ wlog[1][15:0], 16'h1000 ^ 16'h0012);
        end
        issue(1'b0, 1'b1, 16'h0FFF, 16'h0000, 1'b0);
        chk16("cross_ld", last_rdata, 16'h1234);

        // Out-of-range accesses.
        wlog.delete();
        issue(1'b0, 1'b1, 16'h2FFF, 16'h0000, 1'b0);
        chk1 ("err_half_err", last_err, 1'b1);
        chk16("err_half_lat", 16'(last_lat), 16'd1);
        chk16("err_half_rd", last_rdata, 16'h0);
        issue(1'b1, 1'b0, 16'h3000, 16'h00AA, 1'b0);
        chk1 ("err_byte_err", last_err, 1'b1);
        chk16("err_byte_lat", 16'(last_lat), 16'd1);
        issue(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
        chk1 ("err_ffff", last_err, 1'b1);
        chk16("err_nwr", 16'(wlog.size()), 16'd0);

        // Reset during ACC1 of a halfword store: low byte lands, high byte does not.
        issue(1'b1, 1'b0, 16'h0201, 16'h0077, 1'b0);
        req_write = 1'b1; req_half = 1'b1; req_addr = 16'h0200; req_wdata = 16'hA55A;
        req_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        model_access(1'b1, 1'b1, 16'h0200, 16'hA55A, n);
        req_valid = 1'b0;
        @(posedge clk); #3;
        chk1("acc1_we", mem_we, 1'b1);
        rst_n = 1'b0;
        want_q.delete();
        ref_mem[16'h0201] = 8'h77;
        #1;
        chk1 ("abort_we", mem_we, 1'b0);
        chk16("abort_a", mem_a, 16'h0);
        chk1 ("abort_rv", resp_valid, 1'b0);
        chk1 ("abort_ready", req_ready, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        chk1("hold_rst_ready", req_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 1'b1, 16'h0200, 16'h0000, 1'b0);
        chk16("post_rst_ld", last_rdata, 16'h775A);
        chk16("post_rst_lat", 16'(last_lat), 16'd3);

        // req_valid held with changing fields while busy.
        issue(1'b0, 1'b0, 16'h1000, 16'h0000, 1'b1);
        chk16("hold_ld", last_rdata, 16'h0012);

        // Randomized traffic, biased towards the range boundaries.
        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 11))
                0:       a = 16'h2FFF;
                1:       a = 16'h3000;
                2:       a = 16'hFFFF;
                3:       a = 16'h2FFE;
                4:       a = 16'h0FFF;
                5:       a = 16'($urandom);
                default: a = 16'($urandom_range(0, 12287));
            endcase
            issue(1'($urandom), 1'($urandom), a, 16'($urandom), 1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) begin
                scramble();
                @(posedge clk); #1;
            end
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
